// File: rtl/result_checker.sv
// rtl/result_checker.sv - data-memory write-bus monitor comparing result words against golden values
module result_checker #(
   parameter int unsigned ADDR_W    = 30,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned NUM_WORDS = 8,
   parameter int unsigned BASE_ADDR = 0,
   parameter bit          BYTE_SWAP = 1'b1,
   parameter int unsigned TIMEOUT   = 65535,
   parameter int unsigned ERR_W     = 8,
   parameter int unsigned DUR_W     = 16,
   parameter int unsigned IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] data,
   input  logic              wen,
   input  logic              exp_wen,
   input  logic [IDX_W-1:0]  exp_idx,
   input  logic [DATA_W-1:0] exp_data,
   output logic [ERR_W-1:0]  error_num,
   output logic [DUR_W-1:0]  duration,
   output logic              finish,
   output logic              pass,
   output logic              timeout
);

   typedef enum logic [1:0] {
      S_RUN  = 2'd0,
      S_DONE = 2'd1,
      S_TOUT = 2'd2
   } state_t;

   localparam int unsigned     NB      = DATA_W / 8;
   localparam logic [ADDR_W:0] WIN_LO  = (ADDR_W+1)'(BASE_ADDR);
   localparam logic [ADDR_W:0] WIN_HI  = WIN_LO + (ADDR_W+1)'(NUM_WORDS);
   localparam logic [ERR_W-1:0] ERR_MAX = '1;
   localparam logic [DUR_W-1:0] DUR_MAX = '1;
   localparam logic [DUR_W:0]  TMO_VAL = (DUR_W+1)'(TIMEOUT);

   state_t                 state;
   state_t                 state_nxt;
   logic                   wen_d;
   logic [NUM_WORDS-1:0]   seen;
   logic [NUM_WORDS-1:0]   seen_nxt;
   logic [NUM_WORDS-1:0]   onehot;
   logic [DATA_W-1:0]      exp_mem [NUM_WORDS];
   logic [DATA_W-1:0]      swapped;
   logic [DATA_W-1:0]      cmp;
   logic [IDX_W-1:0]       idx;
   logic                   in_win;
   logic                   acc;
   logic                   first_wr;
   logic                   mismatch;
   logic                   all_seen;
   logic [DUR_W:0]         dur_inc;
   logic                   tmo_hit;

   // Golden words survive reset so a mid-run reset does not need a reload.
   always_ff @(posedge clk) begin
      if (exp_wen && (32'(exp_idx) < NUM_WORDS)) begin
         exp_mem[exp_idx] <= exp_data;
      end
   end

   for (genvar b = 0; b < NB; b++) begin : g_swap
      assign swapped[8*b +: 8] = data[8*(NB-1-b) +: 8];
   end

   assign cmp    = BYTE_SWAP ? swapped : data;
   assign in_win = ({1'b0, addr} >= WIN_LO) && ({1'b0, addr} < WIN_HI);
   assign idx    = IDX_W'(addr - ADDR_W'(BASE_ADDR));

   // Rising-edge detect on wen so a write stretched by cache stalls counts once.
   assign acc      = wen && !wen_d && in_win && (state == S_RUN);
   assign onehot   = NUM_WORDS'(1) << idx;
   assign first_wr = acc && !seen[idx];
   assign mismatch = first_wr && (cmp != exp_mem[idx]);
   assign seen_nxt = seen | (acc ? onehot : '0);
   assign all_seen = &seen_nxt;
   assign dur_inc  = {1'b0, duration} + 1'b1;
   assign tmo_hit  = (dur_inc == TMO_VAL);

   always_comb begin
      state_nxt = state;
      finish    = 1'b0;
      pass      = 1'b0;
      timeout   = 1'b0;
      case (state)
         S_RUN: begin
            if (all_seen) begin
               state_nxt = S_DONE;
            end else if (tmo_hit) begin
               state_nxt = S_TOUT;
            end
         end
         S_DONE: begin
            finish = 1'b1;
            pass   = (error_num == '0);
         end
         S_TOUT: begin
            finish  = 1'b1;
            timeout = 1'b1;
         end
         default: state_nxt = S_RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= S_RUN;
         wen_d     <= 1'b0;
         seen      <= '0;
         error_num <= '0;
         duration  <= '0;
      end else begin
         state <= state_nxt;
         wen_d <= wen;
         if (acc) begin
            seen <= seen_nxt;
         end
         if (mismatch && (error_num != ERR_MAX)) begin
            error_num <= error_num + 1'b1;
         end
         if ((state == S_RUN) && (duration != DUR_MAX)) begin
            duration <= duration + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_result_checker.sv
// tb/tb_result_checker.sv - directed scoreboard bench for result_checker
module tb_result_checker;

   localparam int ADDR_W = 30;
   localparam int DATA_W = 32;
   localparam int ERR_W  = 8;
   localparam int DUR_W  = 16;
   localparam int IDX_W  = 2;

   typedef struct {
      int err;
      int pass;
      int tout;
      int dur;
   } res_t;

   logic              clk;
   logic              rst;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] data;
   logic              wen;
   logic              exp_wen;
   logic [IDX_W-1:0]  exp_idx;
   logic [DATA_W-1:0] exp_data;
   logic [ERR_W-1:0]  error_num;
   logic [DUR_W-1:0]  duration;
   logic              finish;
   logic              pass;
   logic              timeout;

   int   n_assert = 0;
   int   n_fail   = 0;
   res_t sb[$];

   result_checker #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_WORDS(4), .BASE_ADDR(32'h10),
      .BYTE_SWAP(1'b1), .TIMEOUT(20), .ERR_W(ERR_W), .DUR_W(DUR_W)
   ) dut (
      .clk(clk), .rst(rst), .addr(addr), .data(data), .wen(wen),
      .exp_wen(exp_wen), .exp_idx(exp_idx), .exp_data(exp_data),
      .error_num(error_num), .duration(duration), .finish(finish),
      .pass(pass), .timeout(timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input int n);
      addr = a;
      data = d;
      wen  = 1'b1;
      repeat (n) tick();
      wen  = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      tick();
      tick();
      rst = 1'b1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_assert++;
      assert (got === want) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, want);
      end
   endtask

   task automatic push(input int err, input int p, input int t, input int dur);
      res_t r;
      r.err  = err;
      r.pass = p;
      r.tout = t;
      r.dur  = dur;
      sb.push_back(r);
   endtask

   task automatic check_result(input string tag, input int max_wait);
      res_t r;
      int   w = 0;
      while (finish !== 1'b1 && w < max_wait) begin
         tick();
         w++;
      end
      chk({tag, ".finish"}, 32'(finish), 32'd1);
      r = sb.pop_front();
      chk({tag, ".error_num"}, 32'(error_num), 32'(r.err));
      chk({tag, ".pass"}, 32'(pass), 32'(r.pass));
      chk({tag, ".timeout"}, 32'(timeout), 32'(r.tout));
      chk({tag, ".duration"}, 32'(duration), 32'(r.dur));
   endtask

   // Correct words on edges 2,4,6,8 after reset release.
   task automatic good_seq();
      idle(1); wr(30'h10, 32'h0100_0000, 1);
      idle(1); wr(30'h11, 32'h0200_0000, 1);
      idle(1); wr(30'h12, 32'h0300_0000, 1);
      idle(1); wr(30'h13, 32'h3200_0000, 1);
   endtask

   initial begin
      logic [DATA_W-1:0] gold [4];
      gold[0] = 32'd1; gold[1] = 32'd2; gold[2] = 32'd3; gold[3] = 32'd50;
      rst = 1'b0; wen = 1'b0; addr = '0; data = '0;
      exp_wen = 1'b0; exp_idx = '0; exp_data = '0;

      // golden load while held in reset
      tick();
      for (int i = 0; i < 4; i++) begin
         exp_wen  = 1'b1;
         exp_idx  = IDX_W'(i);
         exp_data = gold[i];
         tick();
      end
      exp_wen = 1'b0;
      rst = 1'b1;
      chk("reset.error_num", 32'(error_num), 32'd0);
      chk("reset.duration", 32'(duration), 32'd0);
      chk("reset.finish", 32'(finish), 32'd0);
      chk("reset.pass", 32'(pass), 32'd0);
      chk("reset.timeout", 32'(timeout), 32'd0);

      // correct run
      push(0, 1, 0, 8);
      good_seq();
      check_result("correct", 0);
      idle(3);
      chk("correct.dur_frozen", 32'(duration), 32'd8);
      chk("correct.pass_held", 32'(pass), 32'd1);

      // stall filter: bad word held three cycles counts once
      do_reset();
      push(1, 0, 0, 10);
      idle(1); wr(30'h13, 32'h3300_0000, 3);
      chk("stall.error_once", 32'(error_num), 32'd1);
      chk("stall.no_finish", 32'(finish), 32'd0);
      idle(1); wr(30'h10, 32'h0100_0000, 1);
      idle(1); wr(30'h11, 32'h0200_0000, 1);
      idle(1); wr(30'h12, 32'h0300_0000, 1);
      check_result("stall", 0);

      // out-of-window and repeated writes are ignored
      do_reset();
      idle(1); wr(30'h0F, 32'hDEAD_BEEF, 1);
      idle(1); wr(30'h14, 32'hCAFE_F00D, 1);
      idle(1); wr(30'h10, 32'h0100_0000, 1);
      idle(1); wr(30'h10, 32'h9900_0000, 1);
      chk("filter.error_num", 32'(error_num), 32'd0);
      chk("filter.finish", 32'(finish), 32'd0);
      chk("filter.duration", 32'(duration), 32'd8);
      push(0, 1, 0, 14);
      idle(1); wr(30'h11, 32'h0200_0000, 1);
      idle(1); wr(30'h12, 32'h0300_0000, 1);
      chk("filter.not_early", 32'(finish), 32'd0);
      idle(1); wr(30'h13, 32'h3200_0000, 1);
      check_result("filter", 0);

      // timeout with no writes
      do_reset();
      idle(19);
      chk("tout.pre_timeout", 32'(timeout), 32'd0);
      chk("tout.pre_duration", 32'(duration), 32'd19);
      push(0, 0, 1, 20);
      tick();
      check_result("tout", 0);
      idle(3);
      chk("tout.dur_frozen", 32'(duration), 32'd20);
      chk("tout.held", 32'(timeout), 32'd1);

      // completion on the timeout edge: DONE wins
      do_reset();
      idle(1); wr(30'h10, 32'h0100_0000, 1);
      idle(1); wr(30'h11, 32'h0200_0000, 1);
      idle(1); wr(30'h12, 32'h0300_0000, 1);
      idle(13);
      chk("coincide.pre_finish", 32'(finish), 32'd0);
      chk("coincide.pre_duration", 32'(duration), 32'd19);
      push(0, 1, 0, 20);
      wr(30'h13, 32'h3200_0000, 1);
      check_result("coincide", 0);

      // mid-run reset keeps golden words, clears progress
      do_reset();
      idle(1); wr(30'h10, 32'h0100_0000, 1);
      idle(1); wr(30'h11, 32'h0200_0000, 1);
      idle(1);
      rst = 1'b0;
      #1;
      chk("midrst.duration", 32'(duration), 32'd0);
      chk("midrst.error_num", 32'(error_num), 32'd0);
      tick();
      rst = 1'b1;
      push(0, 1, 0, 8);
      idle(1); wr(30'h10, 32'h0100_0000, 1);
      idle(1); wr(30'h11, 32'h0200_0000, 1);
      idle(1); wr(30'h12, 32'h0300_0000, 1);
      chk("midrst.seen_cleared", 32'(finish), 32'd0);
      idle(1); wr(30'h13, 32'h3200_0000, 1);
      check_result("midrst", 0);

      chk("scoreboard.empty", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
